// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the 2-way set-associative 2KB cache (16B blocks,
// 8 x 16-bit words). Holds the address split, the fill FSM state type and
// small address helpers used by the miss-side fill logic.
// ---------------------------------------------------------------------------
package cache_pkg;

  localparam int BLOCK_BYTES     = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_BITS     = 4;
  localparam int INDEX_BITS      = 6;
  localparam int TAG_BITS        = 6;
  localparam int ADDR_BITS       = TAG_BITS + INDEX_BITS + OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } fill_state_t;

  // Block-aligned address: the byte offset within the block is dropped.
  function automatic logic [ADDR_BITS-1:0] blockBase(input logic [ADDR_BITS-1:0] addr);
    return addr & ~ADDR_BITS'(BLOCK_BYTES - 1);
  endfunction

  // Address of word 'cnt' inside the block starting at 'base'. The base has
  // zero offset bits and cnt < 8, so the OR only fills bits [3:1] and can
  // never carry into the index or tag.
  function automatic logic [ADDR_BITS-1:0] wordAddr(input logic [ADDR_BITS-1:0] base,
                                                    input logic [3:0]           cnt);
    return base | {{(ADDR_BITS - 5){1'b0}}, cnt, 1'b0};
  endfunction

endpackage

// File: rtl/fill_counter.sv
// ---------------------------------------------------------------------------
// fill_counter
// Word counter for one side (issue or receive) of a cache block fill.
// Counts from 0 up to LIMIT and then holds; 'done' is high at LIMIT.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset (count -> 0)
//   clear - synchronous clear (count -> 0), has priority over inc
//   inc   - increment enable; ignored once done
//   count - current count
//   done  - count has reached LIMIT
// ---------------------------------------------------------------------------
module fill_counter #(
  parameter int LIMIT = 8,
  parameter int CNT_W = $clog2(LIMIT) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  assign done = (count == CNT_W'(LIMIT));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of always-block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !done) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm
// Miss-side responder for the cache. On a miss it reads the whole 16B block
// from pipelined memory (one request per cycle), writes each returned word
// into the data array as it arrives, then issues one tag/valid write.
// fsm_busy stalls the core for the whole fill.
//
// Ports:
//   clk, rst           - clock and asynchronous active-high reset
//   miss_detected      - miss request, sampled only in IDLE
//   miss_address       - missing byte address, sampled only in IDLE
//   fsm_busy           - fill in progress (FILL and TAG)
//   write_data_array   - data-array write strobe, one per returned word
//   write_tag_array    - metadata write strobe, one cycle after last word
//   cache_address      - byte address of the current data or tag write
//   cache_data         - word written into the data array
//   memory_address     - byte address of the current memory read
//   memory_read_en     - memory read request, one word per cycle
//   memory_data        - memory read data
//   memory_data_valid  - memory_data valid; in request order, may have gaps
//
// All outputs are combinational from state, counters and inputs, so a data
// write happens in the same cycle its memory_data_valid is seen.
// ---------------------------------------------------------------------------
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  output logic              fsm_busy,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] cache_address,
  output logic [DATA_W-1:0] cache_data,
  output logic [ADDR_W-1:0] memory_address,
  output logic              memory_read_en,
  input  logic [DATA_W-1:0] memory_data,
  input  logic              memory_data_valid
);

  import cache_pkg::*;

  fill_state_t       state, nextState;
  logic [ADDR_W-1:0] baseAddr;

  logic       cntClear;
  logic       issueInc, recvInc;
  logic [3:0] issueCnt, recvCnt;
  logic       issueDone, recvDone;

  // Both counters are held at zero whenever the FSM is idle, so a new fill
  // always starts from word 0 without a separate clear pulse.
  assign cntClear = (state == IDLE);

  fill_counter #(.LIMIT(WORDS_PER_BLOCK)) uIssueCnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cntClear),
    .inc   (issueInc),
    .count (issueCnt),
    .done  (issueDone)
  );

  fill_counter #(.LIMIT(WORDS_PER_BLOCK)) uRecvCnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cntClear),
    .inc   (recvInc),
    .count (recvCnt),
    .done  (recvDone)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baseAddr <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && miss_detected) begin
        baseAddr <= blockBase(miss_address);
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (latch).
    nextState        = state;
    fsm_busy         = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    cache_address    = '0;
    cache_data       = '0;
    memory_address   = '0;
    memory_read_en   = 1'b0;
    issueInc         = 1'b0;
    recvInc          = 1'b0;

    unique case (state)
      IDLE: begin
        if (miss_detected) begin
          nextState = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        // Issue side: one read per cycle until all words are requested.
        if (!issueDone) begin
          memory_read_en = 1'b1;
          memory_address = wordAddr(baseAddr, issueCnt);
          issueInc       = 1'b1;
        end
        // Receive side: independent of the issue side, may run in the same
        // cycle. Beats beyond the last word are dropped.
        if (memory_data_valid && !recvDone) begin
          write_data_array = 1'b1;
          cache_address    = wordAddr(baseAddr, recvCnt);
          cache_data       = memory_data;
          recvInc          = 1'b1;
          if (recvCnt == 4'(WORDS_PER_BLOCK - 1)) begin
            nextState = TAG;
          end
        end
      end

      TAG: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        cache_address   = baseAddr;
        nextState       = IDLE;
      end

      default: begin
        nextState = IDLE;
      end
    endcase
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-side responder for the 2-way set-associative 2KB cache (16B blocks, 8 x 16-bit words).
- Waits for the cache to assert a miss, then fetches the whole 16B block from pipelined main memory.
- Writes each returned word into the cache data array, then issues a single metadata (tag/valid) write.
- Holds the core stalled via fsm_busy for the whole fill.

Parameters:
- WORDS_PER_BLOCK, 8, words per cache block; fixes counter width (3 bits plus a done bit).
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- miss_detected  input  1  cache miss indication; sampled only in IDLE.
- miss_address  input  16  byte address of the missing access; sampled only in IDLE.
- fsm_busy  output  1  high while a fill is in progress; stalls the pipeline.
- write_data_array  output  1  one-cycle strobe per returned word; cache data write enable.
- write_tag_array  output  1  one-cycle strobe after the final word; cache metadata write enable.
- cache_address  output  16  byte address for the current data or tag write.
- cache_data  output  16  word to write into the cache data array.
- memory_address  output  16  byte address of the current memory read.
- memory_read_en  output  1  memory read request, one word per cycle.
- memory_data  input  16  read data returned by memory.
- memory_data_valid  input  1  memory_data valid this cycle; returns in request order and may have gaps.

Behaviour:
- Reset (asynchronous): state=IDLE; both counters=0; base=0. All outputs are 0: fsm_busy, write_data_array, write_tag_array, memory_read_en, memory_address, cache_address, cache_data.
- States:
  - IDLE: miss_detected=1 → latch base={miss_address[15:4],4'h0}, clear counters, go FILL. Bits [3:0] of miss_address are ignored.
  - FILL: runs the issue and receive sides below. On the receive of word 7 → TAG.
  - TAG: write_tag_array=1 and cache_address=base for exactly one cycle → IDLE.
- Issue side (FILL): while issue_cnt<8, memory_read_en=1 and memory_address=base+2*issue_cnt; issue_cnt increments every cycle. Once issue_cnt=8, memory_read_en=0.
- Receive side (FILL): on each memory_data_valid, write_data_array=1, cache_address=base+2*recv_cnt, cache_data=memory_data; recv_cnt increments.
- Output timing: all outputs are combinational from state, counters and inputs. Data-write outputs are valid in the same cycle as memory_data_valid.
- fsm_busy=1 in FILL and TAG; 0 in IDLE. It is 0 in the cycle miss_detected is first seen and 1 from the next cycle.
- Latency with memory latency L (valid arrives L cycles after the request), miss sampled at cycle 0:
  - reads issue at cycles 1–8;
  - data writes occur at cycles 1+L to 8+L;
  - the tag write occurs at cycle 9+L;
  - fsm_busy falls at cycle 10+L.
- Gaps in memory_data_valid stretch FILL. The FSM waits indefinitely and has no timeout.
- Address arithmetic:
  - 16-bit; offset = 2*count, at most 0xE, added into bits [3:0] only, so it never carries into the tag or index.
  - base 0xFFF0 yields 0xFFF0..0xFFFE.
- Ignored events:
  - miss_detected during FILL or TAG.
  - memory_data_valid in IDLE or TAG.
  - extra memory_data_valid beats after recv_cnt reaches 8.
- Simultaneous events: the issue of word k and the receive of word j in the same cycle are both performed.
- Reset mid-fill aborts immediately. Partially written data is left in the data array, but the tag is never written, so the line stays invalid or stale. Memory responses that arrive after reset are ignored per the IDLE rule.
- Metadata content (LRU/valid/tag) is formed by the cache from cache_address. This block supplies only the strobe and the address.

Decomposition:
- Shared package cache_pkg:
  - constants BLOCK_BYTES=16, WORDS_PER_BLOCK=8, OFFSET_BITS=4, INDEX_BITS=6, TAG_BITS=6;
  - the state type fill_state_t {IDLE, FILL, TAG}, 2-bit encoding.
- One sub-module, fill_counter: 4-bit counter with synchronous clear, increment enable, asynchronous reset and a done flag at 8. It is instantiated twice, once for issue and once for receive.

Test Plan:
- Reset with rst=1 and random inputs → every output 0. Release rst; hold miss_detected=0 for 10 cycles → outputs stay 0.
- Basic fill: miss_address=0x1234 at cycle 0, memory model L=4 returning 0xA000+i:
  - memory_address 0x1230,0x1232..0x123E at cycles 1–8;
  - write_data_array at cycles 5–12 with cache_address 0x1230+2i and cache_data 0xA000+i;
  - write_tag_array with cache_address 0x1230 at cycle 13;
  - fsm_busy=1 for cycles 1–13.
- Wrap: miss_address=0xFFFF → reads 0xFFF0..0xFFFE and tag write to 0xFFF0; address never 0x0000.
- Gapped returns: valid deasserted for 3 cycles after word 3 → exactly 8 data writes; tag write one cycle after word 7 (cycle 16); no early exit.
- Busy/ignored events:
  - miss_detected=1 at 0x2000 during the fill → ignored;
  - a stray memory_data_valid in IDLE → no write;
  - a miss at 0x2000 asserted after fsm_busy falls → a new fill of 0x2000..0x200E.
- Reset mid-fill: assert rst at cycle 6 → outputs 0 immediately and write_tag_array never fires; late valids are ignored; a subsequent miss at 0x4010 completes normally.
